ireg_border_skew: RTL and testbench

//  Multi-channel west/north border input register for the unary-temporal systolic array.
//  - Captures CH signed words per enable and converts each to sign + magnitude.
//  - Delays channel c by c extra enabled cycles, giving the diagonal skew the array needs.
//  - Successor of the single-channel border register: adds channel count, built-in skew,
//    a valid bit per lane and saturation of the most-negative input.

---
 rtl/ireg_border_skew_pkg.sv | 31 +++
 rtl/ireg_border_skew_line.sv | 37 +++
 rtl/ireg_border_skew.sv | 66 ++++++
 tb/tb_ireg_border_skew.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ireg_border_skew_pkg.sv
// Shared types for the border input register: sign/magnitude lane word and
// the two's-complement to sign/magnitude conversion.
package ireg_pkg;

    localparam int IREG_WIDTH = 16;

    typedef struct packed {
        logic                  valid;
        logic                  sign;
        logic [IREG_WIDTH-2:0] abs;
    } sm_word_t;

    // The most-negative input has no representable magnitude; sat selects
    // clamping to full scale or the legacy wrap to zero.
    function automatic sm_word_t to_sm(input logic signed [IREG_WIDTH-1:0] d,
                                       input bit sat);
        sm_word_t                     r;
        logic signed [IREG_WIDTH-1:0] neg;
        neg     = -d;
        r.valid = 1'b1;
        r.sign  = d[IREG_WIDTH-1];
        if (!r.sign)
            r.abs = d[IREG_WIDTH-2:0];
        else if (d[IREG_WIDTH-2:0] == '0)
            r.abs = sat ? '1 : '0;
        else
            r.abs = neg[IREG_WIDTH-2:0];
        return r;
    endfunction

endpackage

// File: rtl/ireg_border_skew_line.sv
// Enable-shifted register chain with synchronous clear; DEPTH=0 is a wire.
module ireg_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, en, clr};
            assign q_o         = d_i;
        end else begin : g_chain
            logic [W-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (en) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ireg_border_skew.sv
// Multi-channel border input register: sign/magnitude capture followed by a
// per-channel skew line so channel c arrives c enabled cycles later.
module ireg_border_skew
    import ireg_pkg::*;
#(
    parameter int WIDTH = IREG_WIDTH,
    parameter int CH    = 4,
    parameter bit SAT   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   i_valid,
    input  logic [CH*WIDTH-1:0]    i_data,
    output logic [CH-1:0]          o_valid,
    output logic [CH-1:0]          o_data_sign,
    output logic [CH*(WIDTH-1)-1:0] o_data_abs
);

    localparam int SMW = $bits(sm_word_t);

    sm_word_t cap_d  [CH];
    sm_word_t cap_q  [CH];
    sm_word_t line_q [CH];

    // Bubbles carry zeroed data rather than holding the previous word.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            cap_d[c] = '0;
            if (i_valid)
                cap_d[c] = to_sm(i_data[c*WIDTH +: WIDTH], SAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) cap_q[c] <= '0;
        end else if (clr) begin
            for (int c = 0; c < CH; c++) cap_q[c] <= '0;
        end else if (en) begin
            for (int c = 0; c < CH; c++) cap_q[c] <= cap_d[c];
        end
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            ireg_skew_line #(
                .DEPTH (c),
                .W     (SMW)
            ) u_line (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .clr   (clr),
                .d_i   (cap_q[c]),
                .q_o   (line_q[c])
            );

            assign o_valid[c]                       = line_q[c].valid;
            assign o_data_sign[c]                   = line_q[c].sign;
            assign o_data_abs[c*(WIDTH-1) +: WIDTH-1] = line_q[c].abs;
        end
    endgenerate

endmodule

// File: tb/tb_ireg_border_skew.sv
// Bench for ireg_border_skew: directed vectors plus a per-channel history
// model compared every cycle, on a 4-channel saturating and a 1-channel wrapping instance.
module tb_ireg_border_skew;

    localparam int W  = 16;
    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              rst_n, en, clr, i_valid;
    logic [CH*W-1:0]   i_data;
    logic [W-1:0]      i_data1;
    logic [CH-1:0]     o_valid, o_data_sign;
    logic [CH*(W-1)-1:0] o_data_abs;
    logic [0:0]        o_valid1, o_data_sign1;
    logic [W-2:0]      o_data_abs1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ireg_border_skew #(.WIDTH(W), .CH(CH), .SAT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i_valid(i_valid),
        .i_data(i_data), .o_valid(o_valid), .o_data_sign(o_data_sign),
        .o_data_abs(o_data_abs)
    );

    ireg_border_skew #(.WIDTH(W), .CH(1), .SAT(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i_valid(i_valid),
        .i_data(i_data1), .o_valid(o_valid1), .o_data_sign(o_data_sign1),
        .o_data_abs(o_data_abs1)
    );

    // Model word layout: {valid, sign, abs[14:0]}
    typedef logic [16:0] smw_t;

    logic [CH*17-1:0] hist4 [$];
    smw_t             hist1 [$];

    function automatic smw_t conv(input logic [W-1:0] w, input bit vld, input bit sat);
        int v;
        int a;
        smw_t r;
        if (!vld) return '0;
        v = $signed(w);
        a = (v < 0) ? -v : v;
        if (a > 32767) a = sat ? 32767 : 0;
        r = {1'b1, (v < 0), a[14:0]};
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            hist4.delete();
            hist1.delete();
        end else if (en) begin
            logic [CH*17-1:0] g;
            for (int c = 0; c < CH; c++)
                g[c*17 +: 17] = conv(i_data[c*W +: W], i_valid, 1'b1);
            hist4.push_front(g);
            if (hist4.size() > CH) hist4.pop_back();
            hist1.push_front(conv(i_data1, i_valid, 1'b0));
            if (hist1.size() > 1) hist1.pop_back();
        end
    end

    always @(negedge clk) begin
        smw_t e;
        smw_t a;
        for (int c = 0; c < CH; c++) begin
            e = '0;
            if (hist4.size() > c) e = hist4[c][c*17 +: 17];
            a = {o_valid[c], o_data_sign[c], o_data_abs[c*15 +: 15]};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model_ch%0d at %0t: got %h expected %h", c, $time, a, e);
            end
        end
        e = (hist1.size() > 0) ? hist1[0] : '0;
        a = {o_valid1, o_data_sign1, o_data_abs1};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL model_sat0 at %0t: got %h expected %h", $time, a, e);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick_word();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; i_valid = 1'b0;
        i_data = '0; i_data1 = '0;
        step(2);
        rst_n = 1'b1;
        chk("reset_valid", 64'(o_valid), 64'h0);
        chk("reset_abs", 64'(o_data_abs), 64'h0);

        // Skew: single group of 5s walks diagonally
        en = 1'b1; i_valid = 1'b1; i_data = {4{16'd5}};
        step(1);
        i_valid = 1'b0; i_data = '0;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("skew_valid_c%0d", c), 64'(o_valid), 64'(4'b1 << c));
            chk($sformatf("skew_abs_c%0d", c), 64'(o_data_abs[c*15 +: 15]), 64'd5);
            chk($sformatf("skew_sign_c%0d", c), 64'(o_data_sign), 64'h0);
            step(1);
        end
        chk("skew_drained", 64'(o_valid), 64'h0);

        // Sign / saturation corners
        i_valid = 1'b1;
        i_data  = {16'hFFF9, 16'h7FFF, 16'h8000, 16'hFFFF};
        i_data1 = 16'h8000;
        step(1);
        i_valid = 1'b0; i_data = '0; i_data1 = '0;
        chk("neg1_sign", 64'(o_data_sign[0]), 64'h1);
        chk("neg1_abs", 64'(o_data_abs[14:0]), 64'h1);
        chk("sat0_min", 64'({o_valid1, o_data_sign1, o_data_abs1}), 64'h18000);
        step(1);
        chk("sat1_min_sign", 64'(o_data_sign[1]), 64'h1);
        chk("sat1_min_abs", 64'(o_data_abs[29:15]), 64'h7FFF);
        step(1);
        chk("max_pos", 64'({o_data_sign[2], o_data_abs[44:30]}), 64'h7FFF);
        step(1);
        chk("neg7_ch3", 64'({o_valid[3], o_data_sign[3], o_data_abs[59:45]}), 64'h18007);
        step(1);

        // Stall mid-skew: -7 on ch3 needs exactly 3 enabled edges
        i_valid = 1'b1; i_data = {16'hFFF9, 48'h0};
        step(1);
        i_valid = 1'b0; i_data = '0;
        step(1);
        en = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step(1);
            chk($sformatf("stall_frozen_%0d", s), 64'(o_valid), 64'b0010);
        end
        en = 1'b1;
        step(1);
        chk("stall_edge2", 64'(o_valid), 64'b0100);
        step(1);
        chk("stall_edge3", 64'({o_valid, o_data_sign[3], o_data_abs[59:45]}), 64'h18_8007 >> 0 & 64'hFFFFF);
        step(3);

        // clr beats en; new valid data is discarded
        i_valid = 1'b1; i_data = {16'd1, 16'd2, 16'd3, 16'd4};
        step(3);
        clr = 1'b1; i_data = {4{16'd9}};
        step(1);
        clr = 1'b0; en = 1'b0; i_valid = 1'b0;
        chk("clr_valid", 64'(o_valid), 64'h0);
        chk("clr_abs", 64'(o_data_abs), 64'h0);
        step(1);
        chk("clr_hold", 64'(o_valid), 64'h0);

        // Async reset with all lanes full
        en = 1'b1; i_valid = 1'b1; i_data = {16'hFFFE, 16'd100, 16'h8001, 16'd7};
        step(4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'h0);
        chk("async_rst_data", 64'({o_data_sign, o_data_abs}), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b0;
        step(2);
        chk("post_rst_valid", 64'(o_valid), 64'h0);

        // Random regression, checked by the per-cycle model compare
        for (int n = 0; n < 10000; n++) begin
            en      = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 31) == 0);
            i_valid = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < CH; c++) i_data[c*W +: W] = pick_word();
            i_data1 = pick_word();
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
